// File: rtl/pipe_dest_tracker_if.sv
// Bundle of ID-stage inputs and per-stage destination/status outputs for
// pipe_dest_tracker; the master side drives ID info, the slave side is the tracker.
interface pipe_dest_tracker_if;
  logic [4:0] i_reg_d_ID;
  logic       i_reg_wr_ID;
  logic       i_mem_rd_ID;
  logic       i_valid_ID;
  logic       i_stall;
  logic       i_flush;
  logic       i_md_start;
  logic       i_md_is_div;
  logic       i_mfhilo_ID;

  logic [4:0] o_reg_d_EX;
  logic [4:0] o_reg_d_MM;
  logic [4:0] o_reg_d_WB;
  logic       o_reg_wr_EX;
  logic       o_reg_wr_MM;
  logic       o_reg_wr_WB;
  logic       o_mem_rd_EX;
  logic       o_valid_EX;
  logic       o_valid_MM;
  logic       o_valid_WB;
  logic       o_md_busy;
  logic       o_md_stall;
  logic       o_stall_ID;

  modport master (
    output i_reg_d_ID, i_reg_wr_ID, i_mem_rd_ID, i_valid_ID, i_stall, i_flush,
           i_md_start, i_md_is_div, i_mfhilo_ID,
    input  o_reg_d_EX, o_reg_d_MM, o_reg_d_WB, o_reg_wr_EX, o_reg_wr_MM,
           o_reg_wr_WB, o_mem_rd_EX, o_valid_EX, o_valid_MM, o_valid_WB,
           o_md_busy, o_md_stall, o_stall_ID
  );

  modport slave (
    input  i_reg_d_ID, i_reg_wr_ID, i_mem_rd_ID, i_valid_ID, i_stall, i_flush,
           i_md_start, i_md_is_div, i_mfhilo_ID,
    output o_reg_d_EX, o_reg_d_MM, o_reg_d_WB, o_reg_wr_EX, o_reg_wr_MM,
           o_reg_wr_WB, o_mem_rd_EX, o_valid_EX, o_valid_MM, o_valid_WB,
           o_md_busy, o_md_stall, o_stall_ID
  );
endinterface

// File: rtl/pipe_dest_tracker.sv
// Tracks destination register, write and load flags through EX/MM/WB and
// holds ID while the multiply/divide unit is busy and HI/LO is needed.
module pipe_dest_tracker #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  pipe_dest_tracker_if.slave  bus
);

  localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

  logic [4:0] ex_d, mm_d, wb_d;
  logic       ex_wr, mm_wr, wb_wr;
  logic       ex_mem_rd;
  logic       ex_valid, mm_valid, wb_valid;
  logic [5:0] md_cnt;
  logic       md_busy;
  logic       md_stall;
  logic       acc;

  assign md_busy  = (md_cnt != 6'd0);
  assign md_stall = md_busy & bus.i_valid_ID & (bus.i_mfhilo_ID | bus.i_md_start);
  assign acc      = bus.i_valid_ID & ~bus.i_stall & ~bus.i_flush & ~md_stall;

  // Flush or any stall turns the ID slot into a bubble; stages behind EX never stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_d      <= 5'd0;
      ex_wr     <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_valid  <= 1'b0;
      mm_d      <= 5'd0;
      mm_wr     <= 1'b0;
      mm_valid  <= 1'b0;
      wb_d      <= 5'd0;
      wb_wr     <= 1'b0;
      wb_valid  <= 1'b0;
      md_cnt    <= 6'd0;
    end else begin
      if (acc) begin
        ex_d      <= bus.i_reg_d_ID;
        ex_wr     <= bus.i_reg_wr_ID & (bus.i_reg_d_ID != 5'd0);
        ex_mem_rd <= bus.i_mem_rd_ID;
        ex_valid  <= 1'b1;
      end else begin
        ex_d      <= 5'd0;
        ex_wr     <= 1'b0;
        ex_mem_rd <= 1'b0;
        ex_valid  <= 1'b0;
      end
      mm_d     <= ex_d;
      mm_wr    <= ex_wr;
      mm_valid <= ex_valid;
      wb_d     <= mm_d;
      wb_wr    <= mm_wr;
      wb_valid <= mm_valid;
      // A new MULT/DIV can only be accepted once the counter has drained.
      if (acc & bus.i_md_start)
        md_cnt <= bus.i_md_is_div ? DIV_CNT : MULT_CNT;
      else if (md_busy)
        md_cnt <= md_cnt - 6'd1;
    end
  end

  assign bus.o_reg_d_EX  = ex_d;
  assign bus.o_reg_d_MM  = mm_d;
  assign bus.o_reg_d_WB  = wb_d;
  assign bus.o_reg_wr_EX = ex_wr;
  assign bus.o_reg_wr_MM = mm_wr;
  assign bus.o_reg_wr_WB = wb_wr;
  assign bus.o_mem_rd_EX = ex_mem_rd;
  assign bus.o_valid_EX  = ex_valid;
  assign bus.o_valid_MM  = mm_valid;
  assign bus.o_valid_WB  = wb_valid;
  assign bus.o_md_busy   = md_busy;
  assign bus.o_md_stall  = md_stall;
  assign bus.o_stall_ID  = bus.i_stall | md_stall;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Self-checking bench for pipe_dest_tracker: directed vector table, multi-cycle
// MDU/reset sequences, and random traffic against a cycle-count reference model.
module tb_pipe_dest_tracker;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  pipe_dest_tracker_if bus ();

  pipe_dest_tracker #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic       valid;
    logic [4:0] d;
    logic       wr;
    logic       mem_rd;
    logic       stall;
    logic       flush;
    logic       md_start;
    logic       is_div;
    logic       mfhilo;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic       stall_id;
    logic [4:0] ex_d;
    logic       ex_wr;
    logic       ex_mem_rd;
    logic       ex_valid;
    logic [4:0] mm_d;
    logic [4:0] wb_d;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [4:0] d;
    logic       wr;
    logic       mem_rd;
    logic       valid;
  } stage_t;

  int checks   = 0;
  int failures = 0;

  // Reference model: stage contents as a shift array, MDU as "busy until edge N".
  stage_t pipe[3];
  int     cycle;
  int     busy_end;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic stim_t mk_stim(input logic valid, input logic [4:0] d, input logic wr,
                                    input logic mem_rd, input logic stall, input logic flush,
                                    input logic md_start, input logic is_div, input logic mfhilo);
    stim_t s;
    s = '{valid:valid, d:d, wr:wr, mem_rd:mem_rd, stall:stall, flush:flush,
          md_start:md_start, is_div:is_div, mfhilo:mfhilo};
    return s;
  endfunction

  function automatic vec_t mk_vec(input stim_t s, input logic stall_id, input logic [4:0] ex_d,
                                  input logic ex_wr, input logic ex_mem_rd, input logic ex_valid,
                                  input logic [4:0] mm_d, input logic [4:0] wb_d, input logic busy);
    vec_t v;
    v = '{s:s, stall_id:stall_id, ex_d:ex_d, ex_wr:ex_wr, ex_mem_rd:ex_mem_rd,
          ex_valid:ex_valid, mm_d:mm_d, wb_d:wb_d, busy:busy};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{d:5'd0, wr:1'b0, mem_rd:1'b0, valid:1'b0};
    cycle    = 0;
    busy_end = 0;
  endtask

  function automatic bit model_md_stall(input stim_t s);
    return (cycle < busy_end) && s.valid && (s.mfhilo || s.md_start);
  endfunction

  task automatic model_step(input stim_t s);
    bit acc;
    acc = s.valid && !s.stall && !s.flush && !model_md_stall(s);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (acc) pipe[0] = '{d:s.d, wr:(s.wr && s.d != 5'd0), mem_rd:s.mem_rd, valid:1'b1};
    else     pipe[0] = '{d:5'd0, wr:1'b0, mem_rd:1'b0, valid:1'b0};
    if (acc && s.md_start) busy_end = cycle + 1 + (s.is_div ? DIV_LAT : MULT_LAT);
    cycle++;
  endtask

  task automatic apply_stimulus(input stim_t s);
    bus.i_valid_ID  = s.valid;
    bus.i_reg_d_ID  = s.d;
    bus.i_reg_wr_ID = s.wr;
    bus.i_mem_rd_ID = s.mem_rd;
    bus.i_stall     = s.stall;
    bus.i_flush     = s.flush;
    bus.i_md_start  = s.md_start;
    bus.i_md_is_div = s.is_div;
    bus.i_mfhilo_ID = s.mfhilo;
    #2;
  endtask

  task automatic clock_edge();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_output();
    check("ex_d",      int'(bus.o_reg_d_EX),  int'(pipe[0].d));
    check("ex_wr",     int'(bus.o_reg_wr_EX), int'(pipe[0].wr));
    check("ex_mem_rd", int'(bus.o_mem_rd_EX), int'(pipe[0].mem_rd));
    check("ex_valid",  int'(bus.o_valid_EX),  int'(pipe[0].valid));
    check("mm_d",      int'(bus.o_reg_d_MM),  int'(pipe[1].d));
    check("mm_wr",     int'(bus.o_reg_wr_MM), int'(pipe[1].wr));
    check("mm_valid",  int'(bus.o_valid_MM),  int'(pipe[1].valid));
    check("wb_d",      int'(bus.o_reg_d_WB),  int'(pipe[2].d));
    check("wb_wr",     int'(bus.o_reg_wr_WB), int'(pipe[2].wr));
    check("wb_valid",  int'(bus.o_valid_WB),  int'(pipe[2].valid));
    check("md_busy",   int'(bus.o_md_busy),   int'(cycle < busy_end));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_d"},     int'(bus.o_reg_d_EX),  0);
    check({tag, "_mm_d"},     int'(bus.o_reg_d_MM),  0);
    check({tag, "_wb_d"},     int'(bus.o_reg_d_WB),  0);
    check({tag, "_wr"},       int'({bus.o_reg_wr_EX, bus.o_reg_wr_MM, bus.o_reg_wr_WB}), 0);
    check({tag, "_mem_rd"},   int'(bus.o_mem_rd_EX), 0);
    check({tag, "_valid"},    int'({bus.o_valid_EX, bus.o_valid_MM, bus.o_valid_WB}), 0);
    check({tag, "_md_busy"},  int'(bus.o_md_busy),   0);
  endtask

  task automatic do_reset();
    apply_stimulus(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));
    i_rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    clock_edge();
    clock_edge();
    i_rst_n = 1'b1;
    model_reset();
  endtask

  vec_t  vecs[10];
  stim_t s;
  int    n;

  initial begin
    vecs[0] = mk_vec(mk_stim(1, 5, 1, 0, 0, 0, 0, 0, 0), 0, 5, 1, 0, 1, 0, 0, 0);
    vecs[1] = mk_vec(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 5, 0, 0);
    vecs[2] = mk_vec(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 5, 0);
    vecs[3] = mk_vec(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk_vec(mk_stim(1, 8, 1, 1, 1, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk_vec(mk_stim(1, 8, 1, 1, 0, 0, 0, 0, 0), 0, 8, 1, 1, 1, 0, 0, 0);
    vecs[6] = mk_vec(mk_stim(1, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 1, 8, 0, 0);
    vecs[7] = mk_vec(mk_stim(1, 3, 1, 0, 1, 1, 0, 0, 0), 1, 0, 0, 0, 0, 0, 8, 0);
    vecs[8] = mk_vec(mk_stim(1, 0, 0, 0, 0, 1, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9] = mk_vec(mk_stim(0, 0, 0, 0, 0, 0, 1, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);

    do_reset();

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].s);
      check($sformatf("vec%0d_stall_id", i), int'(bus.o_stall_ID), int'(vecs[i].stall_id));
      check($sformatf("vec%0d_md_stall", i), int'(bus.o_md_stall), 0);
      clock_edge();
      check($sformatf("vec%0d_ex_d", i),      int'(bus.o_reg_d_EX),  int'(vecs[i].ex_d));
      check($sformatf("vec%0d_ex_wr", i),     int'(bus.o_reg_wr_EX), int'(vecs[i].ex_wr));
      check($sformatf("vec%0d_ex_mem_rd", i), int'(bus.o_mem_rd_EX), int'(vecs[i].ex_mem_rd));
      check($sformatf("vec%0d_ex_valid", i),  int'(bus.o_valid_EX),  int'(vecs[i].ex_valid));
      check($sformatf("vec%0d_mm_d", i),      int'(bus.o_reg_d_MM),  int'(vecs[i].mm_d));
      check($sformatf("vec%0d_wb_d", i),      int'(bus.o_reg_d_WB),  int'(vecs[i].wb_d));
      check($sformatf("vec%0d_busy", i),      int'(bus.o_md_busy),   int'(vecs[i].busy));
    end

    // DIV followed by MFLO: MFLO is held for the full divide latency.
    do_reset();
    apply_stimulus(mk_stim(1, 0, 0, 0, 0, 0, 1, 1, 0));
    clock_edge();
    check("div_busy", int'(bus.o_md_busy), 1);
    apply_stimulus(mk_stim(1, 9, 1, 0, 0, 0, 0, 0, 1));
    n = 0;
    while (bus.o_md_stall && n < 100) begin
      check("div_stall_id", int'(bus.o_stall_ID), 1);
      clock_edge();
      check("div_ex_bubble", int'(bus.o_valid_EX), 0);
      n++;
      #1;
    end
    check("div_stall_cycles", n, DIV_LAT);
    check("div_busy_dropped", int'(bus.o_md_busy), 0);
    clock_edge();
    check("mflo_ex_d", int'(bus.o_reg_d_EX), 9);
    check("mflo_ex_valid", int'(bus.o_valid_EX), 1);

    // MULT busy window is exactly MULT_LAT cycles.
    do_reset();
    apply_stimulus(mk_stim(1, 0, 0, 0, 0, 0, 1, 0, 0));
    clock_edge();
    apply_stimulus(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.o_md_busy) n++;
      clock_edge();
    end
    check("mult_busy_cycles", n, MULT_LAT);

    // Reset asserted mid-divide with a full pipe clears everything without a clock.
    do_reset();
    apply_stimulus(mk_stim(1, 0, 0, 0, 0, 0, 1, 1, 0));
    clock_edge();
    for (int k = 0; k < DIV_LAT - 10; k++) begin
      apply_stimulus(mk_stim(1, 5'(k + 1), 1, 0, 0, 0, 0, 0, 0));
      clock_edge();
    end
    check("mid_div_busy", int'(bus.o_md_busy), 1);
    check("mid_div_valid", int'({bus.o_valid_EX, bus.o_valid_MM, bus.o_valid_WB}), 7);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");

    // Random traffic against the reference model.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      s.valid    = ($urandom_range(0, 9) < 8);
      s.d        = 5'($urandom_range(0, 31));
      s.wr       = ($urandom_range(0, 3) != 0);
      s.mem_rd   = ($urandom_range(0, 3) == 0);
      s.stall    = ($urandom_range(0, 6) == 0);
      s.flush    = ($urandom_range(0, 9) == 0);
      s.md_start = ($urandom_range(0, 9) == 0);
      s.is_div   = ($urandom_range(0, 3) == 0);
      s.mfhilo   = ($urandom_range(0, 6) == 0);
      apply_stimulus(s);
      check("rnd_md_stall", int'(bus.o_md_stall), int'(model_md_stall(s)));
      check("rnd_stall_id", int'(bus.o_stall_ID), int'(s.stall || model_md_stall(s)));
      model_step(s);
      clock_edge();
      check_output();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_dest_tracker.md
PIPE_DEST_TRACKER -- requirements
Module: pipe_dest_tracker

Interface
REQ-001 Parameters: MULT_LAT, default 4, multiply busy cycles (range 1..63); DIV_LAT, default 32, divide busy cycles (range 1..63).
REQ-002 i_clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-004 i_reg_d_ID  input  5  destination register of instruction in ID.
REQ-005 i_reg_wr_ID  input  1  ID instruction writes register file.
REQ-006 i_mem_rd_ID  input  1  ID instruction is a load.
REQ-007 i_valid_ID  input  1  ID holds a real instruction.
REQ-008 i_stall  input  1  load-use stall from hazard unit.
REQ-009 i_flush  input  1  taken branch/jump resolved in EX; kills ID.
REQ-010 i_md_start  input  1  ID instruction is MULT/MULTU/DIV/DIVU.
REQ-011 i_md_is_div  input  1  qualifies i_md_start: 1 = divide, 0 = multiply.
REQ-012 i_mfhilo_ID  input  1  ID instruction reads HI/LO.
REQ-013 o_reg_d_EX, o_reg_d_MM, o_reg_d_WB  output  5 each  stage destination registers.
REQ-014 o_reg_wr_EX, o_reg_wr_MM, o_reg_wr_WB  output  1 each  stage register-write flags.
REQ-015 o_mem_rd_EX  output  1  EX instruction is a load.
REQ-016 o_valid_EX, o_valid_MM, o_valid_WB  output  1 each  stage holds a real instruction.
REQ-017 o_md_busy  output  1  multiply/divide unit occupied.
REQ-018 o_md_stall  output  1  combinational: ID held because of HI/LO hazard.
REQ-019 o_stall_ID  output  1  combinational freeze for PC and IF/ID: i_stall | o_md_stall.

Function
REQ-020 Accept condition (combinational): acc = i_valid_ID & ~i_stall & ~i_flush & ~o_md_stall.
REQ-021 On each edge, acc=1: EX gets d=i_reg_d_ID, wr=i_reg_wr_ID & (i_reg_d_ID!=0), mem_rd=i_mem_rd_ID, valid=1.
REQ-022 On each edge, acc=0: EX gets a bubble, d=0, wr=0, mem_rd=0, valid=0.
REQ-023 MM<=EX and WB<=MM every edge unconditionally (d, wr, valid); no back-end stall exists; latency ID->EX->MM->WB is 1 cycle per stage.
REQ-024 A write to $0 never appears as wr=1 in any stage.
REQ-025 MDU counter 6-bit; o_md_busy = (counter != 0).
REQ-026 On edge with acc & i_md_start: counter <= i_md_is_div ? DIV_LAT : MULT_LAT; busy asserted for exactly that many cycles starting next cycle.
REQ-027 Otherwise counter decrements by 1 each edge while nonzero, including stall and flush cycles; never wraps below 0.
REQ-028 o_md_stall = o_md_busy & i_valid_ID & (i_mfhilo_ID | i_md_start); a second MULT/DIV or MFHI/MFLO waits until busy drops.
REQ-029 Simultaneous i_flush and i_md_start: flush wins; no counter load; bubble into EX.
REQ-030 Simultaneous i_stall and i_flush: single bubble; o_stall_ID still follows REQ-019.
REQ-031 i_md_start with i_valid_ID=0 is ignored.
REQ-032 Counter running when o_md_busy ends in same cycle as ID presents MFHI: no stall that cycle (busy already 0).

Reset
REQ-033 i_rst_n low asynchronously clears all stage registers (d=0, wr=0, mem_rd=0, valid=0) and MDU counter (busy=0), including mid-divide.
REQ-034 First edge after i_rst_n rises applies REQ-020..REQ-032 normally.

Verification
REQ-035 ADD d=5 accepted at edge 1 -> o_reg_d_EX=5/wr=1 after edge 1, o_reg_d_MM=5 after edge 2, o_reg_d_WB=5 after edge 3, then bubble propagates.
REQ-036 LW d=8 with i_stall=1 at edge 1 -> EX holds bubble (valid=0, mem_rd=0), o_stall_ID=1; stall released at edge 2 -> o_mem_rd_EX=1, o_reg_d_EX=8.
REQ-037 ADD d=0 wr=1 accepted -> o_reg_wr_EX=0, o_valid_EX=1.
REQ-038 DIV accepted (DIV_LAT=32), MFLO in ID next cycle -> o_md_stall=1 for 32 cycles, MFLO enters EX on edge following busy drop; MULT with flush same cycle -> o_md_busy stays 0.
REQ-039 Reset asserted mid-divide (counter=10) with valid EX/MM/WB -> all outputs 0 immediately, before next clock edge.
